// File: rtl/cla_nibble_seq.sv
// cla_nibble_seq
//   Multi-cycle adder/subtractor. One 4-bit carry-lookahead cell is reused
//   across the NIB = WIDTH/4 nibbles of the operands, least significant
//   nibble first, with the inter-nibble carry held in a register. Latency
//   is NIB cycles from accept to result; throughput is one operation per
//   NIB+2 cycles.
//
//   Optional feature macro: CLA_SEQ_OVF_EN adds the signed-overflow output.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   block can accept an operation (IDLE only)
//   a, b       operands, WIDTH bits
//   sub        0 = a+b, 1 = a-b
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts the result
//   sum        registered result, WIDTH bits
//   c_out      carry out of the MSB (for subtract, 1 = no borrow)
//   ovf        signed overflow (only with CLA_SEQ_OVF_EN)
//   fsm_state  debug view of the controller state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both high. in_ready depends only on state, and
// out_valid depends only on state; neither combinationally follows the
// other side's valid/ready.

module cla_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
`ifdef CLA_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       fsm_state
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("cla_nibble_seq: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;     // already inverted for subtract
  logic              carry;
  logic [IDXW-1:0]   idx;
  logic              last;

  // Carry-lookahead nibble cell
  logic [3:0]        nib_a;
  logic [3:0]        nib_b;
  logic [3:0]        g;
  logic [3:0]        p;
  logic [4:0]        c;
  logic [3:0]        nib_sum;

  assign fsm_state = state;
  assign last      = (idx == IDXW'(NIB - 1));

  assign nib_a = op_a[4*idx +: 4];
  assign nib_b = op_b[4*idx +: 4];

  always_comb begin
    g    = nib_a & nib_b;
    p    = nib_a ^ nib_b;
    c[0] = carry;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
    nib_sum = p ^ c[3:0];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            // Subtract is a + ~b + 1: the +1 enters as the initial carry.
            carry <= sub;
            idx   <= '0;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= nib_sum;
          carry           <= c[4];
          idx             <= idx + IDXW'(1);
          if (last) begin
            c_out <= c[4];
`ifdef CLA_SEQ_OVF_EN
            // Signed overflow: carry into the MSB differs from carry out.
            ovf   <= c[4] ^ c[3];
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
